// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl_if
//  Description : Request/result bundle between a requester and the bit-serial
//                adder controller. The 'sub' member exists only when
//                SERIAL_ADDSUB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDSUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDSUB_EN
    modport master (output start, a, b, cin, sub, input ready, busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output ready, busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input ready, busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl (with helper full_adder)
//  Description : Bit-serial WIDTH-bit adder. One 1-bit full adder is reused
//                for WIDTH cycles, LSB first, with the running carry held in
//                a flip-flop. Optional macro SERIAL_ADDSUB_EN adds a 'sub'
//                request bit that turns the operation into a - b.
//  Revision    : 1.0 - initial release
// ============================================================================

module full_adder (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    count_q, count_d;
    logic             fa_s;
    logic             fa_c;
    logic             sub_req;

`ifdef SERIAL_ADDSUB_EN
    assign sub_req = bus.sub;
`else
    assign sub_req = 1'b0;
`endif

    // The single shared 1-bit adder, always looking at the current LSBs.
    full_adder u_fa (
        .sum   (fa_s),
        .carry (fa_c),
        .a     (opa_q[0]),
        .b     (opb_q[0]),
        .cin   (carry_q)
    );

    // State and datapath registers; reset aborts any running operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
        end
    end

    // Next-state and datapath update: accept in IDLE, one bit per SHIFT cycle.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SHIFT;
                    opa_d   = bus.a;
                    // Subtraction is a + ~b + 1, so invert b and force carry-in.
                    opb_d   = sub_req ? ~bus.b : bus.b;
                    carry_d = sub_req ? 1'b1 : bus.cin;
                    count_d = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            S_SHIFT: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                if (count_q == C_LAST) begin
                    // Final bit: its carry-out is the overflow/no-borrow flag.
                    state_d = S_DONE;
                    cout_d  = fa_c;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.busy  = (state_q == S_SHIFT);
    assign bus.done  = (state_q == S_DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Self-checking bench for serial_adder_ctrl (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH:0]   mon_exp;
    logic             prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the request.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c, input logic s);
        int ai, bi, r;
        logic [WIDTH:0] res;
        ai = int'(a);
        bi = int'(b);
        if (s) begin
            r = (ai - bi + (1 << WIDTH)) % (1 << WIDTH);
            res = {(ai >= bi), r[WIDTH-1:0]};
        end else begin
            r = ai + bi + int'(c);
            res = {(r >= (1 << WIDTH)), r[WIDTH-1:0]};
        end
        return res;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && bus_if.done === 1'b1) begin
            check("done_one_cycle", 32'(prev_done), 32'(0));
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 with no outstanding request");
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus_if.cout, bus_if.sum} !== mon_exp) begin
                    errors++;
                    $display("FAIL result: got cout/sum %h required %h", {bus_if.cout, bus_if.sum}, mon_exp);
                end
            end
        end
        prev_done <= bus_if.done;
    end

    task automatic scramble();
        bus_if.a   = WIDTH'($urandom);
        bus_if.b   = WIDTH'($urandom);
        bus_if.cin = 1'($urandom);
`ifdef SERIAL_ADDSUB_EN
        bus_if.sub = 1'($urandom);
`endif
    endtask

    // Issue one operation starting at the current negedge; returns one cycle
    // after done so the next call can start back-to-back.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic s, input bit hold);
        int busy_cnt;
        bit seen;
        bit rdy;
        logic [WIDTH:0] e;
        rdy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus_if.ready === 1'b1) begin
                rdy = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ready_before_start", 32'(rdy), 32'(1));
        e = model(a, b, c, s);
        bus_if.start = 1'b1;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.cin   = c;
`ifdef SERIAL_ADDSUB_EN
        bus_if.sub   = s;
`endif
        exp_q.push_back(e);
        @(negedge clk);
        if (!hold) bus_if.start = 1'b0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            scramble();
            if (bus_if.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus_if.busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        bus_if.start = 1'b0;
        check("done_seen", 32'(seen), 32'(1));
        check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
        @(negedge clk);
        check("ready_after_done", 32'(bus_if.ready), 32'(1));
        check("result_holds", 32'({bus_if.cout, bus_if.sum}), 32'(e));
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;
        bus_if.cin   = 1'b0;
`ifdef SERIAL_ADDSUB_EN
        bus_if.sub   = 1'b0;
`endif
        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        check("rst_ready", 32'(bus_if.ready), 32'(1));
        check("rst_busy",  32'(bus_if.busy),  32'(0));
        check("rst_done",  32'(bus_if.done),  32'(0));
        check("rst_sum",   32'(bus_if.sum),   32'(0));
        check("rst_cout",  32'(bus_if.cout),  32'(0));
        #1 rst = 1'b0;
        @(negedge clk);

        do_op(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
        do_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_op(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);   // start held, operands toggled
        repeat (2) @(negedge clk);
        check("idle_after_hold", 32'(bus_if.ready), 32'(1));

        // Reset in the middle of a SHIFT: no done, result cleared.
        bus_if.start = 1'b1;
        bus_if.a     = 8'hF0;
        bus_if.b     = 8'h0F;
        bus_if.cin   = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(bus_if.ready), 32'(1));
        check("abort_busy",  32'(bus_if.busy),  32'(0));
        check("abort_sum",   32'(bus_if.sum),   32'(0));
        check("abort_done",  32'(bus_if.done),  32'(0));
        #1 rst = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);
        do_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDSUB_EN
        do_op(8'h10, 8'h03, 1'b0, 1'b1, 1'b0);
        do_op(8'h03, 8'h10, 1'b1, 1'b1, 1'b0);
        do_op(8'h55, 8'h55, 1'b0, 1'b1, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic s;
`ifdef SERIAL_ADDSUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), s, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
